// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit with valid/ready on both sides.
// Fixed latency: accept -> PREP -> ITER (WIDTH cycles) -> FIX -> DONE.
// Multiply is shift-add over the operand magnitudes; divide is restoring division.
// Signs, divide-by-zero and signed overflow are resolved in FIX.
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op0,
  input  logic [WIDTH-1:0] op1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             z_out,
  output logic             n_out,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] op0_q, op0_d, op1_q, op1_d;
  logic [WIDTH:0]   operand_q, operand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] result_lo_q, result_lo_d, result_hi_q, result_hi_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d;

  logic             is_div, is_signed;
  logic [WIDTH:0]   ext0, ext1, mag0, mag1;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];

  // Operand magnitudes carry one extra bit so the most-negative value does not overflow.
  assign ext0 = {is_signed & op0_q[WIDTH-1], op0_q};
  assign ext1 = {is_signed & op1_q[WIDTH-1], op1_q};
  assign mag0 = ext0[WIDTH] ? -ext0 : ext0;
  assign mag1 = ext1[WIDTH] ? -ext1 : ext1;

  // One shift-add step and one restoring-division step.
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? operand_q : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= operand_q;
  assign div_diff  = div_shift[WIDTH-1:0] - operand_q[WIDTH-1:0];

  // Sign-corrected candidate results for FIX.
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_lo_q ? -prod : prod;
  assign quo_fix  = neg_lo_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_hi_q ? -acc_hi_q : acc_hi_q;

  assign cmd_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign result_lo = result_lo_q;
  assign result_hi = result_hi_q;
  assign z_out     = z_q;
  assign n_out     = n_q;
  assign c_out     = c_q;

  // Next-state and datapath updates for each FSM state.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    op0_d       = op0_q;
    op1_d       = op1_q;
    operand_d   = operand_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    cnt_d       = cnt_q;
    neg_lo_d    = neg_lo_q;
    neg_hi_d    = neg_hi_q;
    result_lo_d = result_lo_q;
    result_hi_d = result_hi_q;
    z_d         = z_q;
    n_d         = n_q;
    c_d         = c_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = op;
          op0_d   = op0;
          op1_d   = op1;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_lo_d = ext0[WIDTH] ^ ext1[WIDTH];
        neg_hi_d = ext0[WIDTH];
        acc_hi_d = '0;
        if (is_div) begin
          acc_lo_d  = mag0[WIDTH-1:0];
          operand_d = mag1;
        end else begin
          acc_lo_d  = mag1[WIDTH-1:0];
          operand_d = mag0;
        end
        cnt_d   = CW'(WIDTH - 1);
        state_d = S_ITER;
      end
      S_ITER: begin
        if (is_div) begin
          acc_hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        if (!is_div) begin
          result_lo_d = prod_fix[WIDTH-1:0];
          result_hi_d = prod_fix[2*WIDTH-1:WIDTH];
          z_d = (prod_fix == '0);
          n_d = result_hi_d[WIDTH-1];
          c_d = is_signed ? (result_hi_d != {WIDTH{result_lo_d[WIDTH-1]}})
                          : (result_hi_d != '0);
        end else begin
          if (op1_q == '0) begin
            result_lo_d = '1;
            result_hi_d = op0_q;
            c_d = 1'b1;
          end else if (is_signed && op0_q == MOST_NEG && op1_q == '1) begin
            result_lo_d = op0_q;
            result_hi_d = '0;
            c_d = 1'b1;
          end else begin
            result_lo_d = quo_fix;
            result_hi_d = rem_fix;
            c_d = 1'b0;
          end
          z_d = (result_lo_d == '0);
          n_d = result_lo_d[WIDTH-1];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      op0_q       <= '0;
      op1_q       <= '0;
      operand_q   <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      cnt_q       <= '0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      op0_q       <= op0_d;
      op1_q       <= op1_d;
      operand_q   <= operand_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      cnt_q       <= cnt_d;
      neg_lo_q    <= neg_lo_d;
      neg_hi_q    <= neg_hi_d;
      result_lo_q <= result_lo_d;
      result_hi_q <= result_hi_d;
      z_q         <= z_d;
      n_q         <= n_d;
      c_q         <= c_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit at WIDTH=16, plus a WIDTH=8 instance.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        cmd_valid, cmd_ready, res_valid, res_ready;
  logic [1:0]  op;
  logic [15:0] op0, op1, result_lo, result_hi;
  logic        z_out, n_out, c_out;

  logic        c8_valid, c8_ready, r8_valid, r8_ready;
  logic [1:0]  op_8;
  logic [7:0]  op0_8, op1_8, lo_8, hi_8;
  logic        z_8, n_8, c_8;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .op(op), .op0(op0), .op1(op1), .res_valid(res_valid), .res_ready(res_ready),
    .result_lo(result_lo), .result_hi(result_hi),
    .z_out(z_out), .n_out(n_out), .c_out(c_out)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .cmd_valid(c8_valid), .cmd_ready(c8_ready),
    .op(op_8), .op0(op0_8), .op1(op1_8), .res_valid(r8_valid), .res_ready(r8_ready),
    .result_lo(lo_8), .result_hi(hi_8),
    .z_out(z_8), .n_out(n_8), .c_out(c_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one command, then count edges until res_valid (bounded).
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       output int lat);
    @(negedge clk);
    cmd_valid = 1'b1; op = o; op0 = a; op1 = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0; op = ~o; op0 = ~a; op1 = ~b;
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_val({tag, "_cmd_ready_after"}, cmd_ready, 1'b1);
    check_val({tag, "_res_valid_after"}, res_valid, 1'b0);
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [15:0] a, b, lo, hi;
    logic        z, n, c;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat;
    logic [15:0] lo_hold, hi_hold;

    vecs[0]  = '{2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{2'b01, 16'hFFFE, 16'h0003, 16'hFFFA, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{2'b01, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{2'b10, 16'h03E8, 16'h0007, 16'h008E, 16'h0006, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{2'b11, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{2'b10, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{2'b11, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{2'b01, 16'h8000, 16'h0001, 16'h8000, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{2'b11, 16'h8000, 16'h0002, 16'hC000, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{2'b11, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0; op = '0; op0 = '0; op1 = '0;
    c8_valid = 1'b0; r8_ready = 1'b0; op_8 = '0; op0_8 = '0; op1_8 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check_val("rst_cmd_ready", cmd_ready, 1'b1);
    check_val("rst_res_valid", res_valid, 1'b0);
    check_val("rst_lo", result_lo, 16'h0);
    check_val("rst_hi", result_hi, 16'h0);
    check_val("rst_flags", {z_out, n_out, c_out}, 3'b000);

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].o, vecs[i].a, vecs[i].b, lat);
      check_val($sformatf("v%0d_latency", i), lat, 18);
      check_val($sformatf("v%0d_lo", i), result_lo, vecs[i].lo);
      check_val($sformatf("v%0d_hi", i), result_hi, vecs[i].hi);
      check_val($sformatf("v%0d_z", i), z_out, vecs[i].z);
      check_val($sformatf("v%0d_n", i), n_out, vecs[i].n);
      check_val($sformatf("v%0d_c", i), c_out, vecs[i].c);
      release_result($sformatf("v%0d", i));
      check_val($sformatf("v%0d_lo_kept", i), result_lo, vecs[i].lo);
    end

    // Backpressure: result held for 10 cycles while a new command is offered.
    issue(2'b10, 16'h03E8, 16'h0007, lat);
    check_val("bp_latency", lat, 18);
    lo_hold = result_lo;
    hi_hold = result_hi;
    check_val("bp_lo_initial", lo_hold, 16'h008E);
    @(negedge clk);
    cmd_valid = 1'b1; op = 2'b00; op0 = 16'h0002; op1 = 16'h0002;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check_val($sformatf("bp_cmd_ready_%0d", k), cmd_ready, 1'b0);
      check_val($sformatf("bp_res_valid_%0d", k), res_valid, 1'b1);
      check_val($sformatf("bp_lo_%0d", k), result_lo, 16'h008E);
      check_val($sformatf("bp_hi_%0d", k), result_hi, 16'h0006);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    check_val("bp_cmd_ready_after", cmd_ready, 1'b1);
    check_val("bp_res_valid_after", res_valid, 1'b0);
    check_val("bp_lo_after", result_lo, 16'h008E);

    // Abort: reset during ITER clears everything; next multiply is clean.
    @(negedge clk);
    cmd_valid = 1'b1; op = 2'b00; op0 = 16'h1234; op1 = 16'h5678;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("abort_cmd_ready", cmd_ready, 1'b1);
    check_val("abort_res_valid", res_valid, 1'b0);
    check_val("abort_lo", result_lo, 16'h0);
    check_val("abort_hi", result_hi, 16'h0);
    check_val("abort_flags", {z_out, n_out, c_out}, 3'b000);
    issue(2'b00, 16'h0003, 16'h0005, lat);
    check_val("post_abort_latency", lat, 18);
    check_val("post_abort_lo", result_lo, 16'h000F);
    check_val("post_abort_hi", result_hi, 16'h0000);
    release_result("post_abort");

    // WIDTH=8 instance: MULU FF*FF, 10-edge latency.
    @(negedge clk);
    c8_valid = 1'b1; op_8 = 2'b00; op0_8 = 8'hFF; op1_8 = 8'hFF;
    @(posedge clk); #1;
    c8_valid = 1'b0; op0_8 = 8'h00; op1_8 = 8'h00;
    lat = 0;
    while (!r8_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("w8_latency", lat, 10);
    check_val("w8_lo", lo_8, 8'h01);
    check_val("w8_hi", hi_8, 8'hFE);
    check_val("w8_flags", {z_8, n_8, c_8}, 3'b011);
    @(negedge clk);
    r8_ready = 1'b1;
    @(posedge clk); #1;
    r8_ready = 1'b0;
    check_val("w8_cmd_ready_after", c8_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
